// File: rtl/ppu_vram_arbiter.sv
// Single-port PPU VRAM arbiter: background fetcher, sprite fetcher and a
// one-entry buffered CPU port, with starvation protection for the CPU.
module ppu_vram_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rendering_en,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              bg_gnt,
  output logic              bg_data_valid,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_gnt,
  output logic              spr_data_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_overrun,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_PEND = 2'd1;
  localparam logic [1:0] C_WAIT = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_BG   = 2'd1;
  localparam logic [1:0] OWN_SPR  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [1:0]        c_state_reg;
  logic              cpu_we_reg;
  logic [ADDR_W-1:0] cpu_addr_reg;
  logic [DATA_W-1:0] cpu_wdata_reg;
  logic [7:0]        starve_cnt_reg;
  logic [1:0]        owner_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] wdata_hold_reg;
  logic [DATA_W-1:0] cpu_rdata_reg;
  logic              cpu_done_reg;
  logic              cpu_overrun_reg;

  logic cpu_pend;
  logic cpu_starved;
  logic gnt_bg;
  logic gnt_spr;
  logic gnt_cpu;
  logic [1:0] owner_next;

  assign cpu_pend    = (c_state_reg == C_PEND);
  assign cpu_starved = (starve_cnt_reg == STARVE_MAX);

  // Grants are held off during reset so nothing reaches the VRAM while rst is high.
  always_comb begin
    gnt_bg  = 1'b0;
    gnt_spr = 1'b0;
    gnt_cpu = 1'b0;
    if (!rst) begin
      if (!rendering_en) begin
        if (cpu_pend)     gnt_cpu = 1'b1;
        else if (bg_req)  gnt_bg  = 1'b1;
        else if (spr_req) gnt_spr = 1'b1;
      end else begin
        if (cpu_pend && cpu_starved) gnt_cpu = 1'b1;
        else if (bg_req)             gnt_bg  = 1'b1;
        else if (spr_req)            gnt_spr = 1'b1;
        else if (cpu_pend)           gnt_cpu = 1'b1;
      end
    end
  end

  always_comb begin
    if (gnt_cpu)      vram_addr = cpu_addr_reg;
    else if (gnt_bg)  vram_addr = bg_addr;
    else if (gnt_spr) vram_addr = spr_addr;
    else              vram_addr = addr_hold_reg;
  end

  assign vram_we    = gnt_cpu & cpu_we_reg;
  assign vram_wdata = vram_we ? cpu_wdata_reg : wdata_hold_reg;

  always_comb begin
    owner_next = OWN_NONE;
    if (gnt_bg)                     owner_next = OWN_BG;
    else if (gnt_spr)               owner_next = OWN_SPR;
    else if (gnt_cpu && !cpu_we_reg) owner_next = OWN_CPU;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_state_reg     <= C_IDLE;
      cpu_we_reg      <= 1'b0;
      cpu_addr_reg    <= '0;
      cpu_wdata_reg   <= '0;
      starve_cnt_reg  <= 8'd0;
      owner_reg       <= OWN_NONE;
      addr_hold_reg   <= '0;
      wdata_hold_reg  <= '0;
      cpu_rdata_reg   <= '0;
      cpu_done_reg    <= 1'b0;
      cpu_overrun_reg <= 1'b0;
    end else begin
      addr_hold_reg  <= vram_addr;
      wdata_hold_reg <= vram_wdata;
      owner_reg      <= owner_next;
      cpu_done_reg   <= 1'b0;

      // Any request outside C_IDLE (including the cycle the buffer drains) is dropped.
      if (cpu_req && c_state_reg != C_IDLE)
        cpu_overrun_reg <= 1'b1;

      case (c_state_reg)
        C_IDLE: begin
          if (cpu_req) begin
            cpu_we_reg    <= cpu_we;
            cpu_addr_reg  <= cpu_addr;
            cpu_wdata_reg <= cpu_wdata;
            c_state_reg   <= C_PEND;
          end
        end
        C_PEND: begin
          if (gnt_cpu) begin
            if (cpu_we_reg) begin
              c_state_reg  <= C_IDLE;
              cpu_done_reg <= 1'b1;
            end else begin
              c_state_reg <= C_WAIT;
            end
          end
        end
        C_WAIT: begin
          cpu_rdata_reg <= vram_rdata;
          cpu_done_reg  <= 1'b1;
          c_state_reg   <= C_IDLE;
        end
        default: c_state_reg <= C_IDLE;
      endcase

      if (!cpu_pend || gnt_cpu)
        starve_cnt_reg <= 8'd0;
      else if (rendering_en && !cpu_starved)
        starve_cnt_reg <= starve_cnt_reg + 8'd1;
    end
  end

  assign bg_gnt         = gnt_bg;
  assign spr_gnt        = gnt_spr;
  assign bg_data_valid  = (owner_reg == OWN_BG);
  assign spr_data_valid = (owner_reg == OWN_SPR);
  assign cpu_busy       = (c_state_reg != C_IDLE);
  assign cpu_done       = cpu_done_reg;
  assign cpu_rdata      = cpu_rdata_reg;
  assign cpu_overrun    = cpu_overrun_reg;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter with a one-cycle-latency VRAM model.
module tb_ppu_vram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              rendering_en;
  logic              bg_req;
  logic [ADDR_W-1:0] bg_addr;
  logic              bg_gnt;
  logic              bg_data_valid;
  logic              spr_req;
  logic [ADDR_W-1:0] spr_addr;
  logic              spr_gnt;
  logic              spr_data_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_busy;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_overrun;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [DATA_W-1:0] vram_wdata;
  logic [DATA_W-1:0] vram_rdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int vec_cnt = 0;
  int err_cnt = 0;
  int done_seen;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  ppu_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rendering_en(rendering_en),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt), .bg_data_valid(bg_data_valid),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_data_valid(spr_data_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_overrun(cpu_overrun),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [70:0] outs;
    rst = 1; rendering_en = 1; bg_req = 1; spr_req = 1; cpu_req = 1; cpu_we = 1;
    bg_addr = 14'h0042; spr_addr = 14'h0777; cpu_addr = 14'h0333; cpu_wdata = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      if (c > 0) begin
        outs = {bg_gnt, spr_gnt, bg_data_valid, spr_data_valid, cpu_busy, cpu_done, cpu_overrun,
                vram_we, 25'd0, vram_addr, vram_wdata, cpu_rdata};
        vec_cnt++; if (outs !== '0) begin err_cnt++; $display("FAIL reset_outputs cycle %0d: got %h want 0", c, outs); end
      end
    end
    tick(); rst = 0; cpu_req = 0; #1;
    $display("reset released: bg_gnt=%0b vram_addr=%h", bg_gnt, vram_addr);
    vec_cnt++; if (bg_gnt !== 1'b1) begin err_cnt++; $display("FAIL reset_release_bg_gnt: got %b want 1", bg_gnt); end
    vec_cnt++; if (vram_addr !== 14'h0042) begin err_cnt++; $display("FAIL reset_release_addr: got %h want 0042", vram_addr); end
  endtask

  task automatic test_renderer_priority();
    tick(); rendering_en = 1; bg_req = 1; spr_req = 1; bg_addr = 14'h0100; spr_addr = 14'h1FF0; #1;
    $display("renderer both: bg_gnt=%0b spr_gnt=%0b addr=%h", bg_gnt, spr_gnt, vram_addr);
    vec_cnt++; if ({bg_gnt, spr_gnt} !== 2'b10) begin err_cnt++; $display("FAIL prio_bg_gnt: got %b want 10", {bg_gnt, spr_gnt}); end
    vec_cnt++; if (vram_addr !== 14'h0100) begin err_cnt++; $display("FAIL prio_bg_addr: got %h want 0100", vram_addr); end
    tick(); bg_req = 0; #1;
    $display("renderer spr: spr_gnt=%0b addr=%h bg_dv=%0b", spr_gnt, vram_addr, bg_data_valid);
    vec_cnt++; if (bg_data_valid !== 1'b1) begin err_cnt++; $display("FAIL prio_bg_dv: got %b want 1", bg_data_valid); end
    vec_cnt++; if ({bg_gnt, spr_gnt} !== 2'b01) begin err_cnt++; $display("FAIL prio_spr_gnt: got %b want 01", {bg_gnt, spr_gnt}); end
    vec_cnt++; if (vram_addr !== 14'h1FF0) begin err_cnt++; $display("FAIL prio_spr_addr: got %h want 1FF0", vram_addr); end
    tick(); spr_req = 0; #1;
    $display("renderer idle: spr_dv=%0b addr=%h", spr_data_valid, vram_addr);
    vec_cnt++; if ({bg_data_valid, spr_data_valid} !== 2'b01) begin err_cnt++; $display("FAIL prio_spr_dv: got %b want 01", {bg_data_valid, spr_data_valid}); end
    vec_cnt++; if ({bg_gnt, spr_gnt, vram_we} !== 3'b000) begin err_cnt++; $display("FAIL prio_no_grant: got %b want 000", {bg_gnt, spr_gnt, vram_we}); end
    vec_cnt++; if (vram_addr !== 14'h1FF0) begin err_cnt++; $display("FAIL prio_addr_hold: got %h want 1FF0", vram_addr); end
  endtask

  task automatic test_cpu_write();
    tick(); rendering_en = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 14'h2005; cpu_wdata = 8'hA5; #1;
    vec_cnt++; if (cpu_busy !== 1'b0) begin err_cnt++; $display("FAIL wr_busy_req_cycle: got %b want 0", cpu_busy); end
    tick(); cpu_req = 0; bg_req = 1; bg_addr = 14'h0200; #1;
    $display("cpu write grant: we=%0b addr=%h wdata=%h bg_gnt=%0b", vram_we, vram_addr, vram_wdata, bg_gnt);
    vec_cnt++; if ({vram_we, vram_addr, vram_wdata} !== {1'b1, 14'h2005, 8'hA5}) begin err_cnt++; $display("FAIL wr_grant_bus: got we=%b addr=%h data=%h want 1 2005 A5", vram_we, vram_addr, vram_wdata); end
    vec_cnt++; if ({cpu_busy, bg_gnt} !== 2'b10) begin err_cnt++; $display("FAIL wr_busy_cpu_first: got %b want 10", {cpu_busy, bg_gnt}); end
    tick(); bg_req = 0; #1;
    $display("cpu write done: done=%0b busy=%0b", cpu_done, cpu_busy);
    vec_cnt++; if ({cpu_done, cpu_busy, vram_we} !== 3'b100) begin err_cnt++; $display("FAIL wr_done: got %b want 100", {cpu_done, cpu_busy, vram_we}); end
    vec_cnt++; if (vram_wdata !== 8'hA5) begin err_cnt++; $display("FAIL wr_wdata_hold: got %h want A5", vram_wdata); end
    tick(); #1;
    vec_cnt++; if (cpu_done !== 1'b0) begin err_cnt++; $display("FAIL wr_done_single: got %b want 0", cpu_done); end
  endtask

  task automatic test_cpu_read();
    tick(); rendering_en = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 14'h23C0; cpu_wdata = 8'h5A;
    tick(); cpu_req = 0;
    tick(); tick();
    tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 14'h23C0; #1;
    tick(); cpu_req = 0; #1;
    $display("cpu read grant: addr=%h we=%0b", vram_addr, vram_we);
    vec_cnt++; if ({vram_we, vram_addr} !== {1'b0, 14'h23C0}) begin err_cnt++; $display("FAIL rd_grant_bus: got we=%b addr=%h want 0 23C0", vram_we, vram_addr); end
    tick(); #1;
    vec_cnt++; if ({cpu_busy, cpu_done, bg_data_valid, spr_data_valid} !== 4'b1000) begin err_cnt++; $display("FAIL rd_wait: got %b want 1000", {cpu_busy, cpu_done, bg_data_valid, spr_data_valid}); end
    tick(); #1;
    $display("cpu read done: done=%0b busy=%0b rdata=%h", cpu_done, cpu_busy, cpu_rdata);
    vec_cnt++; if ({cpu_done, cpu_busy, bg_data_valid, spr_data_valid} !== 4'b1000) begin err_cnt++; $display("FAIL rd_done: got %b want 1000", {cpu_done, cpu_busy, bg_data_valid, spr_data_valid}); end
    vec_cnt++; if (cpu_rdata !== 8'h5A) begin err_cnt++; $display("FAIL rd_data: got %h want 5A", cpu_rdata); end
  endtask

  task automatic test_starvation();
    tick(); rendering_en = 1; bg_req = 1; bg_addr = 14'h0300; spr_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h23C0; #1;
    vec_cnt++; if (bg_gnt !== 1'b1) begin err_cnt++; $display("FAIL starve_req_cycle_bg: got %b want 1", bg_gnt); end
    tick(); cpu_req = 0; #1;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin tick(); #1; end
      vec_cnt++; if ({bg_gnt, cpu_busy, vram_addr} !== {2'b11, 14'h0300}) begin err_cnt++; $display("FAIL starve_pend_%0d: got gnt=%b busy=%b addr=%h want 1 1 0300", c, bg_gnt, cpu_busy, vram_addr); end
    end
    tick(); #1;
    $display("starvation grant: bg_gnt=%0b addr=%h", bg_gnt, vram_addr);
    vec_cnt++; if ({bg_gnt, vram_addr} !== {1'b0, 14'h23C0}) begin err_cnt++; $display("FAIL starve_cpu_grant: got gnt=%b addr=%h want 0 23C0", bg_gnt, vram_addr); end
    tick(); #1;
    vec_cnt++; if ({bg_gnt, bg_data_valid} !== 2'b10) begin err_cnt++; $display("FAIL starve_bg_resume: got %b want 10", {bg_gnt, bg_data_valid}); end
    tick(); #1;
    vec_cnt++; if ({cpu_done, cpu_rdata} !== {1'b1, 8'h5A}) begin err_cnt++; $display("FAIL starve_read_done: got done=%b data=%h want 1 5A", cpu_done, cpu_rdata); end
    bg_req = 0;
  endtask

  task automatic test_overrun();
    done_seen = 0;
    tick(); rendering_en = 1; bg_req = 1; bg_addr = 14'h0300;
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0123; cpu_wdata = 8'h11; #1;
    tick(); cpu_addr = 14'h0456; cpu_wdata = 8'h22; #1;
    vec_cnt++; if ({cpu_busy, cpu_overrun} !== 2'b10) begin err_cnt++; $display("FAIL ovr_before: got %b want 10", {cpu_busy, cpu_overrun}); end
    tick(); bg_req = 0; cpu_addr = 14'h0789; cpu_wdata = 8'h33; #1;
    $display("overrun: ovr=%0b addr=%h wdata=%h we=%0b", cpu_overrun, vram_addr, vram_wdata, vram_we);
    vec_cnt++; if (cpu_overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_set: got %b want 1", cpu_overrun); end
    vec_cnt++; if ({vram_we, vram_addr, vram_wdata} !== {1'b1, 14'h0123, 8'h11}) begin err_cnt++; $display("FAIL ovr_latched: got we=%b addr=%h data=%h want 1 0123 11", vram_we, vram_addr, vram_wdata); end
    tick(); cpu_req = 0; #1;
    if (cpu_done === 1'b1) done_seen++;
    vec_cnt++; if (cpu_busy !== 1'b0) begin err_cnt++; $display("FAIL ovr_drain_drop: got busy=%b want 0", cpu_busy); end
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      if (cpu_done === 1'b1) done_seen++;
    end
    vec_cnt++; if (done_seen != 1) begin err_cnt++; $display("FAIL ovr_done_count: got %0d want 1", done_seen); end
    vec_cnt++; if (cpu_overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_sticky: got %b want 1", cpu_overrun); end
  endtask

  task automatic test_back_to_back();
    tick(); rendering_en = 1; bg_req = 1; spr_req = 0; bg_addr = 14'h2005; #1;
    tick(); bg_req = 0; spr_req = 1; spr_addr = 14'h0123; #1;
    $display("b2b: bg_dv=%0b rdata=%h spr_gnt=%0b", bg_data_valid, vram_rdata, spr_gnt);
    vec_cnt++; if ({bg_data_valid, vram_rdata} !== {1'b1, 8'hA5}) begin err_cnt++; $display("FAIL b2b_bg_data: got dv=%b data=%h want 1 A5", bg_data_valid, vram_rdata); end
    vec_cnt++; if ({spr_gnt, vram_addr} !== {1'b1, 14'h0123}) begin err_cnt++; $display("FAIL b2b_spr_gnt: got gnt=%b addr=%h want 1 0123", spr_gnt, vram_addr); end
    tick(); spr_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0456; #1;
    vec_cnt++; if ({spr_data_valid, vram_rdata} !== {1'b1, 8'h11}) begin err_cnt++; $display("FAIL b2b_spr_data: got dv=%b data=%h want 1 11", spr_data_valid, vram_rdata); end
    tick(); cpu_req = 0; #1;
    vec_cnt++; if ({bg_gnt, spr_gnt, vram_addr} !== {2'b00, 14'h0456}) begin err_cnt++; $display("FAIL b2b_cpu_lowprio: got %b addr=%h want 00 0456", {bg_gnt, spr_gnt}, vram_addr); end
    tick(); tick(); bg_req = 1; bg_addr = 14'h0010; #1;
    tick(); bg_req = 0; rst = 1; #1;
    tick(); rst = 0; #1;
    vec_cnt++; if ({bg_data_valid, spr_data_valid, cpu_overrun} !== 3'b000) begin err_cnt++; $display("FAIL b2b_reset_dv: got %b want 000", {bg_data_valid, spr_data_valid, cpu_overrun}); end
  endtask

  initial begin
    test_reset();
    test_renderer_priority();
    test_cpu_write();
    test_cpu_read();
    test_starvation();
    test_overrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ppu_vram_arbiter.md
# ppu_vram_arbiter

Shares the single-port PPU VRAM between the background fetcher, the sprite fetcher (`PPU_sprite`) and CPU PPUDATA accesses. Each cycle it grants at most one requester, drives the VRAM address, write-enable and write-data, and routes returned read data back with a per-requester valid strobe. CPU accesses are buffered and protected from starvation. The block sits between the PPU renderers and the VRAM (pattern/nametable memory) instance.

## Interface
- ADDR_W, 14, VRAM address width
- DATA_W, 8, VRAM data width
- STARVE_LIMIT, 16, cycles a pending CPU access may wait during rendering before it is forced through (range 1..255)

Ports:
- clk  in  1  system clock; everything is clocked on the rising edge
- rst  in  1  synchronous, active-high reset
- rendering_en  in  1  1 while background or sprite rendering is enabled
- bg_req  in  1  background fetch request (level)
- bg_addr  in  ADDR_W  background fetch address
- bg_gnt  out  1  background granted this cycle
- bg_data_valid  out  1  vram_rdata belongs to background this cycle
- spr_req  in  1  sprite fetch request (level; driven from spr_vram_req)
- spr_addr  in  ADDR_W  sprite fetch address (from vram_addr_out)
- spr_gnt  out  1  sprite granted this cycle
- spr_data_valid  out  1  vram_rdata belongs to sprite this cycle
- cpu_req  in  1  single-cycle CPU access pulse
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  ADDR_W  CPU address; sampled with cpu_req
- cpu_wdata  in  DATA_W  CPU write data; sampled with cpu_req
- cpu_busy  out  1  CPU access pending or in flight
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  last CPU read result, held until the next read completes
- cpu_overrun  out  1  sticky: cpu_req arrived while cpu_busy was high
- vram_addr  out  ADDR_W  VRAM address
- vram_we  out  1  VRAM write enable
- vram_wdata  out  DATA_W  VRAM write data
- vram_rdata  in  DATA_W  VRAM read data; the memory has one cycle of read latency

## Operation
- The CPU buffer is one entry deep, with states C_IDLE, C_PEND and C_WAIT.
  - C_IDLE + cpu_req: latch we/addr/wdata, go to C_PEND.
  - C_PEND + granted: a write goes to C_IDLE; a read goes to C_WAIT.
  - C_WAIT: capture vram_rdata into cpu_rdata, go to C_IDLE.
- cpu_req while busy: the request is dropped, the buffer is not modified, and cpu_overrun is set. cpu_overrun is cleared only by rst.
- cpu_req in the same cycle the buffer returns to C_IDLE counts as busy and is dropped.
- Per-cycle arbitration is combinational on the current requests and registered state.
  - rendering_en=0: CPU first, then bg, then spr.
  - rendering_en=1: starved CPU first, then bg, then spr, then CPU.
- Starvation counter (8 bit):
  - Increments each cycle the buffer is in C_PEND, rendering_en=1 and the CPU is not granted. It saturates at STARVE_LIMIT.
  - The CPU is starved when the counter equals STARVE_LIMIT.
  - The counter clears on a CPU grant and when the buffer is in C_IDLE.
- Granted cycle:
  - vram_addr = the winner's address.
  - vram_we = 1 only for a CPU write, with vram_wdata = the latched cpu_wdata.
  - Exactly one of bg_gnt, spr_gnt or the internal CPU grant is high.
- No grant: vram_addr holds its last driven value, vram_we=0, vram_wdata holds.
- Owner pipeline: a 2-bit register records the winner of cycle N, and drives bg_data_valid / spr_data_valid in N+1. CPU writes do not produce a data-valid strobe.
- Reset values: bg_gnt, spr_gnt, bg_data_valid, spr_data_valid, cpu_busy, cpu_done, cpu_overrun, vram_we = 0; vram_addr, vram_wdata, cpu_rdata = 0.
- Internal reset state: CPU buffer in C_IDLE, starvation counter 0, owner register = none.
- rst mid-operation drops any pending or in-flight access. No data-valid strobe is produced after reset.

## Timing
- Renderer access: request and grant in cycle N, vram_addr presented in N, data on vram_rdata with *_data_valid in N+1.
- CPU access with cpu_req in cycle N:
  - The earliest grant is N+1; cpu_busy is high from N+1.
  - Write granted in G: cpu_done pulses in G+1 and cpu_busy falls in G+1.
  - Read granted in G: cpu_rdata is loaded at the end of G+1; cpu_done pulses and cpu_busy falls in G+2.
- Worst-case CPU latency with rendering_en=1 and bg/spr both held high: grant no later than STARVE_LIMIT+1 cycles after entering C_PEND.
- Back-to-back renderer grants are allowed every cycle. Throughput is one access per cycle.

## Test plan
- Reset: hold rst for 3 cycles with all requests high. Every output must be 0. After release, bg_gnt must be 1 in the first cycle.
- Renderer priority: rendering_en=1, bg_req=spr_req=1, bg_addr=0x0100, spr_addr=0x1FF0. Expect bg_gnt=1, vram_addr=0x0100, and bg_data_valid in the next cycle. Then drop bg_req: spr_gnt=1, vram_addr=0x1FF0.
- CPU write, idle PPU: rendering_en=0, cpu_req with we=1, addr=0x2005, wdata=0xA5. Next cycle: vram_we=1, vram_addr=0x2005, vram_wdata=0xA5. The cycle after that: cpu_done=1, cpu_busy=0.
- CPU read: preload VRAM 0x23C0=0x5A, then issue a read. cpu_done must pulse 3 cycles after cpu_req with cpu_rdata=0x5A. bg_data_valid and spr_data_valid must stay 0.
- Starvation: STARVE_LIMIT=4, rendering_en=1, bg_req held at 1, then a CPU read. The CPU must be granted exactly 5 cycles after entering C_PEND (bg_gnt=0 that cycle). bg resumes the following cycle.
- Overrun: a second cpu_req while cpu_busy=1 must set cpu_overrun=1. The latched address must be unchanged, and only one cpu_done is produced.
